turn_timer: RTL

- Loadable down-counter that times a player's decision window in the blackjack game.
- It is the counterpart of the game's up-counters: those count events up from zero; this block counts a loaded value down to zero and signals timeout.
- A prescaler turns the system clock into timer steps.
- The game FSM drives it: load the time allowance, start, pause or resume, and react to the expired pulse by forcing a "stand".

---
 rtl/turn_timer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/turn_timer.sv
// Loadable prescaled down-counter timing a player's decision window; pulses expired on timeout.
// Optional TURN_TIMER_AUTO_RELOAD_EN: restart from the last loaded value instead of stopping at zero.
module turn_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 50000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] q,
    output logic             running,
    output logic             zero,
    output logic             expired
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             expired_q, expired_d;
`ifdef TURN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pre_q     <= '0;
            expired_q <= 1'b0;
`ifdef TURN_TIMER_AUTO_RELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            expired_q <= expired_d;
`ifdef TURN_TIMER_AUTO_RELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    // clear > load > pause > start > count; pause also masks start in every state
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pre_d     = pre_q;
        expired_d = 1'b0;
`ifdef TURN_TIMER_AUTO_RELOAD_EN
        reload_d  = reload_q;
`endif
        if (clear) begin
            count_d = '0;
            pre_d   = '0;
            state_d = IDLE;
        end else if (load) begin
            count_d = load_value;
`ifdef TURN_TIMER_AUTO_RELOAD_EN
            reload_d = load_value;
`endif
            pre_d   = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !pause && (count_q != '0)) begin
                        state_d = RUN;
                        pre_d   = '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end
                        if (count_q == WIDTH'(1)) begin
                            expired_d = 1'b1;
                            state_d   = EXPIRED;
`ifdef TURN_TIMER_AUTO_RELOAD_EN
                            if (reload_q != '0) begin
                                count_d = reload_q;
                                state_d = RUN;
                            end
`endif
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
                    state_d = EXPIRED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign q       = count_q;
    assign running = (state_q == RUN);
    assign zero    = (count_q == '0);
    assign expired = expired_q;

endmodule
